// File: rtl/apb_add_master.sv
// apb_add_master
//   APB (AMBA3, no PPROT/PSTRB) requester for a read-increment-write helper.
//   A READ command fetches TARGET_ADDR and keeps the returned word internally;
//   a WRITE command stores (kept word + INCR) back to the same address.
//
// Ports
//   pclk       in   1       APB clock, rising edge
//   preset_n   in   1       synchronous active-low reset
//   add_i      in   2       00 NOP, 01 READ, 11 WRITE, 10 NOP
//   psel_o     out  1       APB select
//   penable_o  out  1       APB enable (access phase)
//   paddr_o    out  ADDR_W  APB address
//   pwrite_o   out  1       1 = write, 0 = read
//   pwdata_o   out  DATA_W  APB write data
//   prdata_i   in   DATA_W  APB read data
//   pready_i   in   1       completer ready, low inserts a wait state
//   pslverr_i  in   1       completer error   (APB_ADD_PSLVERR_EN only)
//   err_o      out  1       sticky error flag (APB_ADD_PSLVERR_EN only)
//
// Configuration
//   APB_ADD_PSLVERR_EN : when defined, adds pslverr_i/err_o. An erroring read
//   leaves the kept word untouched and sets err_o until reset.

module apb_add_master #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] TARGET_ADDR = 'hA000,
  parameter logic [DATA_W-1:0] INCR        = 1
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic [1:0]        add_i,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
`ifdef APB_ADD_PSLVERR_EN
  ,
  input  logic              pslverr_i,
  output logic              err_o
`endif
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            r_state;
  logic [DATA_W-1:0] r_rdata;

  logic [DATA_W-1:0] w_wdata;
  logic              w_rd_ok;

  // Wraps modulo 2^DATA_W by construction.
  assign w_wdata = r_rdata + INCR;

`ifdef APB_ADD_PSLVERR_EN
  assign w_rd_ok = ~pslverr_i;
`else
  assign w_rd_ok = 1'b1;
`endif

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      r_state   <= StIdle;
      r_rdata   <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      paddr_o   <= '0;
      pwrite_o  <= 1'b0;
      pwdata_o  <= '0;
`ifdef APB_ADD_PSLVERR_EN
      err_o     <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
          // Commands are only looked at here; anything seen mid-transfer is dropped.
          if (add_i == 2'b01) begin
            r_state  <= StSetup;
            psel_o   <= 1'b1;
            paddr_o  <= TARGET_ADDR;
            pwrite_o <= 1'b0;
            pwdata_o <= '0;
          end else if (add_i == 2'b11) begin
            r_state  <= StSetup;
            psel_o   <= 1'b1;
            paddr_o  <= TARGET_ADDR;
            pwrite_o <= 1'b1;
            pwdata_o <= w_wdata;
          end
        end

        StSetup: begin
          penable_o <= 1'b1;
          r_state   <= StAccess;
        end

        StAccess: begin
          // paddr/pwrite/pwdata are simply not touched, so they stay stable.
          if (pready_i) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            r_state   <= StIdle;
            if (!pwrite_o && w_rd_ok) begin
              r_rdata <= prdata_i;
            end
`ifdef APB_ADD_PSLVERR_EN
            if (pslverr_i) begin
              err_o <= 1'b1;
            end
`endif
          end
        end

        default: begin
          r_state   <= StIdle;
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_add_master.sv
module tb_apb_add_master;

  localparam logic [31:0] TADDR = 32'hA000;

  logic        clk;
  logic        preset_n;
  logic [1:0]  add_i;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
`ifdef APB_ADD_PSLVERR_EN
  logic        pslverr;
  logic        err;
`endif

  int n_err;
  int n_chk;

  // Reference model: the kept word and what the bus should show while idle.
  logic [31:0] m_rdata;
  logic        m_pwrite;
  logic [31:0] m_pwdata;
  logic [31:0] m_paddr;

  apb_add_master dut (
    .pclk      (clk),
    .preset_n  (preset_n),
    .add_i     (add_i),
    .psel_o    (psel),
    .penable_o (penable),
    .paddr_o   (paddr),
    .pwrite_o  (pwrite),
    .pwdata_o  (pwdata),
    .prdata_i  (prdata),
    .pready_i  (pready)
`ifdef APB_ADD_PSLVERR_EN
    ,
    .pslverr_i (pslverr),
    .err_o     (err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {psel, penable, pwrite, paddr, pwdata}
  function automatic logic [66:0] bus_now();
    return {psel, penable, pwrite, paddr, pwdata};
  endfunction

  // One complete transfer starting from an idle negedge; ends on the idle negedge after it.
  task automatic run_transfer(input logic [1:0] cmd, input int waits,
                              input logic [31:0] rd_val, input logic [1:0] busy_cmd);
    logic        exp_w;
    logic [31:0] exp_d;
    logic [66:0] exp;
    exp_w = (cmd == 2'b11);
    exp_d = exp_w ? m_rdata + 32'd1 : 32'd0;

    add_i  = cmd;
    pready = 1'($urandom);          // ignored in idle
    prdata = $urandom;
    @(posedge clk); @(negedge clk);
    exp = {1'b1, 1'b0, exp_w, TADDR, exp_d};
    n_chk++;
    if (bus_now() !== exp) begin
      n_err++;
      $display("FAIL setup: got %h want %h", bus_now(), exp);
    end

    add_i  = busy_cmd;
    pready = 1'($urandom);          // ignored in setup
    @(posedge clk); @(negedge clk);
    exp = {1'b1, 1'b1, exp_w, TADDR, exp_d};
    n_chk++;
    if (bus_now() !== exp) begin
      n_err++;
      $display("FAIL access: got %h want %h", bus_now(), exp);
    end

    for (int i = 0; i < waits; i++) begin
      pready = 1'b0;
      prdata = $urandom;
      @(posedge clk); @(negedge clk);
      n_chk++;
      if (bus_now() !== exp) begin
        n_err++;
        $display("FAIL access_wait: got %h want %h", bus_now(), exp);
      end
    end

    pready = 1'b1;
    prdata = rd_val;
    @(posedge clk); @(negedge clk);
    if (!exp_w) m_rdata = rd_val;
    m_pwrite = exp_w;
    m_pwdata = exp_d;
    m_paddr  = TADDR;
    exp = {1'b0, 1'b0, m_pwrite, m_paddr, m_pwdata};
    n_chk++;
    if (bus_now() !== exp) begin
      n_err++;
      $display("FAIL complete: got %h want %h", bus_now(), exp);
    end
    pready = 1'b0;
    add_i  = 2'b00;
  endtask

  task automatic test_reset();
    logic [66:0] exp;
    preset_n = 1'b0;
    add_i    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      n_chk++;
      if (bus_now() !== 67'd0) begin
        n_err++;
        $display("FAIL reset: got %h want 0", bus_now());
      end
    end
    preset_n = 1'b1;
    m_rdata = 0; m_pwrite = 0; m_pwdata = 0; m_paddr = 0;
    exp = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      n_chk++;
      if (bus_now() !== exp) begin
        n_err++;
        $display("FAIL reset_idle: got %h want %h", bus_now(), exp);
      end
    end
  endtask

  task automatic test_nop_gap(input int cycles);
    logic [66:0] exp;
    for (int i = 0; i < cycles; i++) begin
      add_i  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
      pready = 1'($urandom);
      prdata = $urandom;
      @(posedge clk); @(negedge clk);
      exp = {1'b0, 1'b0, m_pwrite, m_paddr, m_pwdata};
      n_chk++;
      if (bus_now() !== exp) begin
        n_err++;
        $display("FAIL nop: got %h want %h", bus_now(), exp);
      end
    end
    add_i  = 2'b00;
    pready = 1'b0;
  endtask

  task automatic test_read_write();
    run_transfer(2'b01, 1, 32'h15, 2'b00);
    run_transfer(2'b11, 0, 32'h0, 2'b00);   // expects pwdata 16
  endtask

  task automatic test_wrap();
    run_transfer(2'b01, 0, 32'hFFFF_FFFF, 2'b00);
    run_transfer(2'b11, 0, 32'h0, 2'b00);   // expects pwdata 0
  endtask

  task automatic test_back_to_back();
    // add_i effectively held at 01 in idle; 11 shown during access must be dropped.
    for (int i = 0; i < 3; i++) run_transfer(2'b01, 0, $urandom, 2'b11);
    run_transfer(2'b11, 0, 32'h0, 2'b01);
  endtask

  task automatic test_reset_mid();
    logic [66:0] exp;
    add_i = 2'b01;
    @(posedge clk); @(negedge clk);
    add_i  = 2'b00;
    pready = 1'b0;
    @(posedge clk); @(negedge clk);
    exp = {1'b1, 1'b1, 1'b0, TADDR, 32'd0};
    n_chk++;
    if (bus_now() !== exp) begin
      n_err++;
      $display("FAIL mid_access: got %h want %h", bus_now(), exp);
    end
    preset_n = 1'b0;
    prdata   = 32'h1234_5678;
    @(posedge clk); @(negedge clk);
    n_chk++;
    if (bus_now() !== 67'd0) begin
      n_err++;
      $display("FAIL mid_reset: got %h want 0", bus_now());
    end
    preset_n = 1'b1;
    m_rdata = 0; m_pwrite = 0; m_pwdata = 0; m_paddr = 0;
    test_nop_gap(1);
    run_transfer(2'b11, 0, 32'h0, 2'b00);   // expects pwdata 1
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_transfer(($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11, $urandom_range(0, 3),
                   $urandom, 2'($urandom));
      if ($urandom_range(0, 1) == 1) test_nop_gap($urandom_range(1, 3));
    end
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    preset_n = 1'b0;
    add_i    = 2'b00;
    pready   = 1'b0;
    prdata   = 32'd0;
`ifdef APB_ADD_PSLVERR_EN
    pslverr  = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_read_write();
    test_wrap();
    test_back_to_back();
    test_nop_gap(3);
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
